// File: rtl/rvvi_trace_drain_pkg.sv
// Shared types and constants for the RVVI trace drain: checker state encoding,
// counter widths and the saturating drop-counter helper.
package rvvi_trace_drain_pkg;

  localparam int ORDER_W    = 64;
  localparam int DROP_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  function automatic logic [DROP_CNT_W-1:0] sat_add(input logic [DROP_CNT_W-1:0] a,
                                                    input logic [DROP_CNT_W-1:0] b);
    logic [DROP_CNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[DROP_CNT_W] ? '1 : sum[DROP_CNT_W-1:0];
  endfunction

endpackage

// File: rtl/rvvi_drain_fifo.sv
// Multi-write, single-read event FIFO: up to RETIRE entries written per cycle,
// compacted in ascending lane order; one entry read per cycle from the head.
module rvvi_drain_fifo #(
  parameter int W      = 8,
  parameter int DEPTH  = 8,
  parameter int RETIRE = 2,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [RETIRE-1:0]            wr_valid,
  input  logic [RETIRE-1:0][W-1:0]     wr_data,
  input  logic                         rd_pop,
  output logic [W-1:0]                 rd_data,
  output logic [CNT_W-1:0]             count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] n_wr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Valid lanes land in consecutive slots starting at the write pointer.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    n_wr     = '0;
    for (int i = 0; i < RETIRE; i++) begin
      if (wr_valid[i]) begin
        mem_d[wr_ptr_d] = wr_data[i];
        wr_ptr_d        = ptr_inc(wr_ptr_d);
        n_wr            = n_wr + CNT_W'(1);
      end
    end
    rd_ptr_d = rd_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + n_wr - (rd_pop ? CNT_W'(1) : CNT_W'(0));
  end

  // NOTE: the storage array has no reset; emptiness is tracked by count_q alone,
  // and the read port is forced to zero while empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rd_data = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count   = count_q;

endmodule

// File: rtl/rvvi_trace_drain.sv
// RVVI trace drain for one hart: samples up to RETIRE retirements per clock, checks
// order continuity and halt semantics, and streams buffered events out one per cycle.
module rvvi_trace_drain
  import rvvi_trace_drain_pkg::*;
#(
  parameter int ILEN   = 32,
  parameter int XLEN   = 32,
  parameter int RETIRE = 2,
  parameter int DEPTH  = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [RETIRE-1:0]           valid,
  input  logic [RETIRE*ORDER_W-1:0]   order,
  input  logic [RETIRE*ILEN-1:0]      insn,
  input  logic [RETIRE-1:0]           trap,
  input  logic [RETIRE-1:0]           halt,
  input  logic [RETIRE-1:0]           intr,
  input  logic [RETIRE*2-1:0]         mode,
  input  logic [RETIRE*XLEN-1:0]      pc_rdata,
  input  logic [RETIRE*XLEN-1:0]      pc_wdata,
  output logic                        ev_valid,
  input  logic                        ev_ready,
  output logic [ORDER_W-1:0]          ev_order,
  output logic [ILEN-1:0]             ev_insn,
  output logic [XLEN-1:0]             ev_pc_rdata,
  output logic [XLEN-1:0]             ev_pc_wdata,
  output logic [1:0]                  ev_mode,
  output logic                        ev_trap,
  output logic                        ev_halt,
  output logic                        ev_intr,
  output logic                        order_err,
  output logic                        ovf_err,
  output logic                        halt_err,
  output logic [ORDER_W-1:0]          err_exp,
  output logic [ORDER_W-1:0]          err_got,
  output logic [DROP_CNT_W-1:0]       drop_cnt,
  output logic [1:0]                  state
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ORDER_W-1:0] order;
    logic [ILEN-1:0]    insn;
    logic [XLEN-1:0]    pc_rdata;
    logic [XLEN-1:0]    pc_wdata;
    logic [1:0]         mode;
    logic               trap;
    logic               halt;
    logic               intr;
  } event_t;

  localparam int EV_W = $bits(event_t);

  event_t [RETIRE-1:0] lane_ev;
  event_t              head_ev;
  logic [RETIRE-1:0]   push_lane;
  logic [CNT_W-1:0]    fifo_count;
  logic                pop;

  state_e                 state_q, state_d;
  logic [ORDER_W-1:0]     exp_q, exp_d;
  logic                   order_err_q, order_err_d;
  logic                   ovf_err_q, ovf_err_d;
  logic                   halt_err_q, halt_err_d;
  logic [ORDER_W-1:0]     err_exp_q, err_exp_d;
  logic [ORDER_W-1:0]     err_got_q, err_got_d;
  logic [DROP_CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

  logic [CNT_W-1:0]       n_valid;
  logic [CNT_W-1:0]       free_slots;
  logic                   seeded;
  logic                   halt_seen;

  for (genvar g = 0; g < RETIRE; g++) begin : g_lane
    assign lane_ev[g] = '{
      order:    order[ORDER_W*g +: ORDER_W],
      insn:     insn[ILEN*g +: ILEN],
      pc_rdata: pc_rdata[XLEN*g +: XLEN],
      pc_wdata: pc_wdata[XLEN*g +: XLEN],
      mode:     mode[2*g +: 2],
      trap:     trap[g],
      halt:     halt[g],
      intr:     intr[g]
    };
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d     = state_q;
    exp_d       = exp_q;
    order_err_d = order_err_q;
    ovf_err_d   = ovf_err_q;
    halt_err_d  = halt_err_q;
    err_exp_d   = err_exp_q;
    err_got_d   = err_got_q;
    drop_cnt_d  = drop_cnt_q;
    push_lane   = '0;
    n_valid     = '0;
    seeded      = (state_q != ST_IDLE);
    halt_seen   = 1'b0;

    for (int i = 0; i < RETIRE; i++) begin
      n_valid = n_valid + CNT_W'(valid[i]);
    end
    // Space is judged against the occupancy at the start of the cycle; a pop in
    // the same cycle does not make room for this cycle's burst.
    free_slots = CNT_W'(DEPTH) - fifo_count;

    if (state_q == ST_HALTED) begin
      if (|valid) halt_err_d = 1'b1;
    end else if (n_valid > free_slots) begin
      ovf_err_d  = 1'b1;
      drop_cnt_d = sat_add(drop_cnt_q, DROP_CNT_W'(n_valid));
    end else begin
      for (int i = 0; i < RETIRE; i++) begin
        if (valid[i]) begin
          if (halt_seen) begin
            halt_err_d = 1'b1;
          end else begin
            push_lane[i] = 1'b1;
            if (!seeded) begin
              exp_d  = lane_ev[i].order;
              seeded = 1'b1;
            end
            if (lane_ev[i].order != exp_d) begin
              if (!order_err_d) begin
                err_exp_d = exp_d;
                err_got_d = lane_ev[i].order;
              end
              order_err_d = 1'b1;
            end
            exp_d     = lane_ev[i].order + ORDER_W'(1);
            state_d   = lane_ev[i].halt ? ST_HALTED : ST_RUN;
            halt_seen = lane_ev[i].halt;
          end
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; all next-state
  // arithmetic lives in the always_comb above.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      exp_q       <= '0;
      order_err_q <= 1'b0;
      ovf_err_q   <= 1'b0;
      halt_err_q  <= 1'b0;
      err_exp_q   <= '0;
      err_got_q   <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      order_err_q <= order_err_d;
      ovf_err_q   <= ovf_err_d;
      halt_err_q  <= halt_err_d;
      err_exp_q   <= err_exp_d;
      err_got_q   <= err_got_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  rvvi_drain_fifo #(
    .W      (EV_W),
    .DEPTH  (DEPTH),
    .RETIRE (RETIRE),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (push_lane),
    .wr_data  (lane_ev),
    .rd_pop   (pop),
    .rd_data  (head_ev),
    .count    (fifo_count)
  );

  assign ev_valid    = (fifo_count != '0);
  assign pop         = ev_valid && ev_ready;
  assign ev_order    = head_ev.order;
  assign ev_insn     = head_ev.insn;
  assign ev_pc_rdata = head_ev.pc_rdata;
  assign ev_pc_wdata = head_ev.pc_wdata;
  assign ev_mode     = head_ev.mode;
  assign ev_trap     = head_ev.trap;
  assign ev_halt     = head_ev.halt;
  assign ev_intr     = head_ev.intr;

  assign order_err = order_err_q;
  assign ovf_err   = ovf_err_q;
  assign halt_err  = halt_err_q;
  assign err_exp   = err_exp_q;
  assign err_got   = err_got_q;
  assign drop_cnt  = drop_cnt_q;
  assign state     = state_q;

endmodule

// File: tb/tb_rvvi_trace_drain.sv
// Scoreboard bench for rvvi_trace_drain: directed scenarios followed by randomized
// retirement bursts, checked against a queue-based reference model.
module tb_rvvi_trace_drain;

  localparam int ILEN   = 32;
  localparam int XLEN   = 32;
  localparam int RETIRE = 2;
  localparam int DEPTH  = 8;

  typedef struct {
    bit [63:0]     order;
    bit [ILEN-1:0] insn;
    bit [XLEN-1:0] pc_r;
    bit [XLEN-1:0] pc_w;
    bit [1:0]      mode;
    bit            trap;
    bit            halt;
    bit            intr;
  } ev_t;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic [RETIRE-1:0]         valid;
  logic [RETIRE*64-1:0]      order;
  logic [RETIRE*ILEN-1:0]    insn;
  logic [RETIRE-1:0]         trap, halt, intr;
  logic [RETIRE*2-1:0]       mode;
  logic [RETIRE*XLEN-1:0]    pc_rdata, pc_wdata;
  logic                      ev_valid, ev_ready;
  logic [63:0]               ev_order;
  logic [ILEN-1:0]           ev_insn;
  logic [XLEN-1:0]           ev_pc_rdata, ev_pc_wdata;
  logic [1:0]                ev_mode;
  logic                      ev_trap, ev_halt, ev_intr;
  logic                      order_err, ovf_err, halt_err;
  logic [63:0]               err_exp, err_got;
  logic [15:0]               drop_cnt;
  logic [1:0]                state;

  always #5 clk = ~clk;

  rvvi_trace_drain #(
    .ILEN(ILEN), .XLEN(XLEN), .RETIRE(RETIRE), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .valid(valid), .order(order), .insn(insn),
    .trap(trap), .halt(halt), .intr(intr), .mode(mode),
    .pc_rdata(pc_rdata), .pc_wdata(pc_wdata),
    .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_order(ev_order), .ev_insn(ev_insn),
    .ev_pc_rdata(ev_pc_rdata), .ev_pc_wdata(ev_pc_wdata),
    .ev_mode(ev_mode), .ev_trap(ev_trap), .ev_halt(ev_halt), .ev_intr(ev_intr),
    .order_err(order_err), .ovf_err(ovf_err), .halt_err(halt_err),
    .err_exp(err_exp), .err_got(err_got), .drop_cnt(drop_cnt), .state(state)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: expected output stream plus architectural checker state.
  ev_t       sb[$];
  ev_t       lane[RETIRE];
  int        occ;
  int        m_state;
  bit [63:0] m_exp, m_eexp, m_egot;
  bit        m_oerr, m_ovf, m_herr;
  int        m_drop;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    occ     = 0;
    m_state = 0;
    m_exp   = '0;
    m_eexp  = '0;
    m_egot  = '0;
    m_oerr  = 1'b0;
    m_ovf   = 1'b0;
    m_herr  = 1'b0;
    m_drop  = 0;
  endtask

  task automatic model_step(input bit [RETIRE-1:0] v, input bit rdy);
    int n;
    int pushed;
    bit stop;
    bit pop;
    n      = 0;
    pushed = 0;
    stop   = 1'b0;
    pop    = rdy && (occ > 0);
    for (int i = 0; i < RETIRE; i++) n += int'(v[i]);
    if (m_state == 2) begin
      if (n > 0) m_herr = 1'b1;
    end else if (n > DEPTH - occ) begin
      m_ovf  = 1'b1;
      m_drop = (m_drop + n > 65535) ? 65535 : m_drop + n;
    end else begin
      for (int i = 0; i < RETIRE; i++) begin
        if (!v[i]) continue;
        if (stop) begin
          m_herr = 1'b1;
          continue;
        end
        if (m_state == 0) m_exp = lane[i].order;
        if (lane[i].order != m_exp && !m_oerr) begin
          m_oerr = 1'b1;
          m_eexp = m_exp;
          m_egot = lane[i].order;
        end
        m_exp   = lane[i].order + 64'd1;
        m_state = lane[i].halt ? 2 : 1;
        stop    = lane[i].halt;
        sb.push_back(lane[i]);
        pushed++;
      end
    end
    occ = occ - int'(pop) + pushed;
  endtask

  task automatic check_status();
    check("ev_valid", ev_valid, occ != 0);
    check("state", state, m_state);
    check("order_err", order_err, m_oerr);
    check("ovf_err", ovf_err, m_ovf);
    check("halt_err", halt_err, m_herr);
    check("err_exp", err_exp, m_eexp);
    check("err_got", err_got, m_egot);
    check("drop_cnt", drop_cnt, m_drop);
  endtask

  task automatic set_lane(input int i, input bit [63:0] o, input bit h);
    lane[i].order = o;
    lane[i].halt  = h;
  endtask

  // One clock of stimulus: check state left by the last edge, then drive the next.
  task automatic cycle(input bit [RETIRE-1:0] v, input bit rdy);
    @(posedge clk);
    #1;
    check_status();
    for (int i = 0; i < RETIRE; i++) begin
      lane[i].insn = $urandom;
      lane[i].pc_r = $urandom;
      lane[i].pc_w = $urandom;
      lane[i].mode = 2'($urandom_range(0, 3));
      lane[i].trap = 1'($urandom_range(0, 1));
      lane[i].intr = 1'($urandom_range(0, 1));
      valid[i]              = v[i];
      order[64*i +: 64]     = lane[i].order;
      insn[ILEN*i +: ILEN]  = lane[i].insn;
      pc_rdata[XLEN*i +: XLEN] = lane[i].pc_r;
      pc_wdata[XLEN*i +: XLEN] = lane[i].pc_w;
      mode[2*i +: 2]        = lane[i].mode;
      trap[i]               = lane[i].trap;
      halt[i]               = lane[i].halt;
      intr[i]               = lane[i].intr;
    end
    ev_ready = rdy;
    model_step(v, rdy);
  endtask

  task automatic idle(input int k, input bit rdy);
    for (int j = 0; j < k; j++) cycle('0, rdy);
  endtask

  // Asserted mid-cycle: the FIFO must empty without waiting for a clock edge.
  task automatic do_reset();
    rst_n    = 1'b0;
    valid    = '0;
    ev_ready = 1'b0;
    #1;
    check("rst_ev_valid", ev_valid, 1'b0);
    check("rst_ev_order", ev_order, 64'd0);
    check("rst_state", state, 2'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: compares the head against the scoreboard while valid, pops on handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && ev_valid) begin
        if (sb.size() == 0) begin
          check("ev_valid_unexpected", ev_valid, 1'b0);
        end else begin
          check("ev_order", ev_order, sb[0].order);
          check("ev_insn", ev_insn, sb[0].insn);
          check("ev_pc_rdata", ev_pc_rdata, sb[0].pc_r);
          check("ev_pc_wdata", ev_pc_wdata, sb[0].pc_w);
          check("ev_flags", {ev_mode, ev_trap, ev_halt, ev_intr},
                {sb[0].mode, sb[0].trap, sb[0].halt, sb[0].intr});
          if (ev_ready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    bit [63:0]         gen_next;
    bit [RETIRE-1:0]   v;
    int                rdy_pct;

    valid = '0; order = '0; insn = '0; trap = '0; halt = '0; intr = '0;
    mode = '0; pc_rdata = '0; pc_wdata = '0; ev_ready = 1'b0;
    for (int i = 0; i < RETIRE; i++) set_lane(i, 64'd0, 1'b0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single lane, orders 0,1,2
    set_lane(0, 64'd0, 1'b0); cycle(2'b01, 1'b1);
    set_lane(0, 64'd1, 1'b0); cycle(2'b01, 1'b1);
    set_lane(0, 64'd2, 1'b0); cycle(2'b01, 1'b1);
    idle(3, 1'b1);
    check("t1_state_run", state, 2'd1);
    check("t1_no_order_err", order_err, 1'b0);
    do_reset();

    // Two lanes in one cycle, drained on consecutive cycles
    set_lane(0, 64'd5, 1'b0); set_lane(1, 64'd6, 1'b0);
    cycle(2'b11, 1'b1);
    idle(3, 1'b1);
    do_reset();

    // Order gap: 10,11,13 then 14
    set_lane(0, 64'd10, 1'b0); cycle(2'b01, 1'b1);
    set_lane(0, 64'd11, 1'b0); cycle(2'b01, 1'b1);
    set_lane(0, 64'd13, 1'b0); cycle(2'b01, 1'b1);
    set_lane(0, 64'd14, 1'b0); cycle(2'b01, 1'b1);
    idle(2, 1'b1);
    check("t3_order_err", order_err, 1'b1);
    check("t3_err_exp", err_exp, 64'd12);
    check("t3_err_got", err_got, 64'd13);
    do_reset();

    // Overflow: two per cycle with consumer stalled
    for (int k = 0; k < 5; k++) begin
      set_lane(0, 64'(2 * k), 1'b0); set_lane(1, 64'(2 * k + 1), 1'b0);
      cycle(2'b11, 1'b0);
    end
    idle(1, 1'b0);
    check("t4_ovf_err", ovf_err, 1'b1);
    check("t4_drop_cnt", drop_cnt, 16'd2);
    check("t4_full_valid", ev_valid, 1'b1);
    idle(DEPTH + 2, 1'b1);
    do_reset();

    // Halt on lane 0 with lane 1 valid
    set_lane(0, 64'd100, 1'b1); set_lane(1, 64'd101, 1'b0);
    cycle(2'b11, 1'b1);
    idle(2, 1'b1);
    check("t5_halt_err", halt_err, 1'b1);
    check("t5_state_halted", state, 2'd2);
    set_lane(0, 64'd200, 1'b0); set_lane(1, 64'd201, 1'b0);
    idle(2, 1'b1);
    do_reset();

    // Asynchronous reset with four events buffered
    set_lane(0, 64'd40, 1'b0); set_lane(1, 64'd41, 1'b0); cycle(2'b11, 1'b0);
    set_lane(0, 64'd42, 1'b0); set_lane(1, 64'd43, 1'b0); cycle(2'b11, 1'b0);
    idle(1, 1'b0);
    check("t6_buffered_valid", ev_valid, 1'b1);
    do_reset();

    // Randomized segments, each starting from reset
    for (int seg = 0; seg < 16; seg++) begin
      gen_next = (seg == 3) ? 64'hFFFF_FFFF_FFFF_FFFD : {$urandom, $urandom};
      rdy_pct  = (seg % 3 == 0) ? 20 : 80;
      for (int c = 0; c < 40; c++) begin
        v = RETIRE'($urandom);
        for (int i = 0; i < RETIRE; i++) begin
          if (v[i]) begin
            if ($urandom_range(0, 15) == 0) gen_next += 64'($urandom_range(1, 3));
            set_lane(i, gen_next, $urandom_range(0, 59) == 0);
            gen_next += 64'd1;
          end else begin
            set_lane(i, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
          end
        end
        cycle(v, $urandom_range(0, 99) < rdy_pct);
      end
      idle(DEPTH + 2, 1'b1);
      check("seg_drained", sb.size(), 0);
      do_reset();
    end

    idle(2, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
